hilo_acc_unit: RTL and testbench

HILO_ACC_UNIT -- requirements
Module: hilo_acc_unit

---
 rtl/hilo_acc_unit.sv | 126 ++++++++++++
 tb/tb_hilo_acc_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_acc_unit.sv
// rtl/hilo_acc_unit.sv - HI/LO register pair with multi-cycle mult/div accumulate and direct write path
module hilo_acc_unit #(
  parameter int W      = 32,
  parameter bit BYPASS = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           wr_en,
  input  logic [1:0]     wr_sel,
  input  logic [W-1:0]   wr_hi,
  input  logic [W-1:0]   wr_lo,
  input  logic           rd_en,
  input  logic           op_start,
  input  logic [1:0]     op_mode,
  input  logic           op_done,
  input  logic [2*W-1:0] op_res,
  output logic [W-1:0]   hi_out,
  output logic [W-1:0]   lo_out,
  output logic           busy,
  output logic           stall,
  output logic           err
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam logic [1:0] MODE_OVR = 2'b00;
  localparam logic [1:0] MODE_ADD = 2'b01;
  localparam logic [1:0] MODE_SUB = 2'b10;

  state_e         state_q, state_d;
  logic [1:0]     mode_q, mode_d;
  logic [W-1:0]   hi_q, hi_d;
  logic [W-1:0]   lo_q, lo_d;
  logic           err_q, err_d;

  logic [2*W-1:0] acc_cur;
  logic [2*W-1:0] acc_res;
  logic [1:0]     mode_cap;
  logic           fwd_hi, fwd_lo;

  // HI and LO form one 2W-bit accumulator so the LO->HI carry/borrow is free
  assign acc_cur = {hi_q, lo_q};

  // Reserved mode 11 is folded to overwrite at capture time
  assign mode_cap = (op_mode == 2'b11) ? MODE_OVR : op_mode;

  // Result of the in-flight operation applied to the current accumulator
  always_comb begin
    acc_res = op_res;
    case (mode_q)
      MODE_ADD: acc_res = acc_cur + op_res;
      MODE_SUB: acc_res = acc_cur - op_res;
      default:  acc_res = op_res;
    endcase
  end

  // Next-state for FSM, mode, HI/LO and sticky error
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        // Direct write lands now; a launched op later builds on the written value
        if (wr_en) begin
          if (wr_sel[1]) hi_d = wr_hi;
          if (wr_sel[0]) lo_d = wr_lo;
        end
        if (op_done) err_d = 1'b1;
        if (op_start) begin
          mode_d  = mode_cap;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // Direct writes are dropped here: stalled ones get re-presented,
        // the one coinciding with op_done is lost by design
        if (op_done) begin
          {hi_d, lo_d} = acc_res;
          if (op_start) begin
            mode_d  = mode_cap;
            state_d = ST_BUSY;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (op_start) begin
          err_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset overrides every other input
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_OVR;
      hi_q    <= '0;
      lo_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      err_q   <= err_d;
    end
  end

  // Same-cycle forwarding of a direct write only applies while idle
  assign fwd_hi = BYPASS && (state_q == ST_IDLE) && wr_en && wr_sel[1];
  assign fwd_lo = BYPASS && (state_q == ST_IDLE) && wr_en && wr_sel[0];

  assign hi_out = fwd_hi ? wr_hi : hi_q;
  assign lo_out = fwd_lo ? wr_lo : lo_q;
  assign busy   = (state_q == ST_BUSY);
  assign stall  = busy & (rd_en | wr_en) & ~op_done;
  assign err    = err_q;

endmodule

// File: tb/tb_hilo_acc_unit.sv
// tb/tb_hilo_acc_unit.sv - self-checking bench for hilo_acc_unit with behavioural model
module tb_hilo_acc_unit;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset, wr_en, rd_en, op_start, op_done;
  logic [1:0]     wr_sel, op_mode;
  logic [W-1:0]   wr_hi, wr_lo;
  logic [2*W-1:0] op_res;

  logic [W-1:0]   hi_out1, lo_out1, hi_out0, lo_out0;
  logic           busy1, stall1, err1, busy0, stall0, err0;

  // Behavioural model: one 64-bit accumulator plus protocol state
  logic [63:0]    m_acc;
  bit             m_busy;
  logic [1:0]     m_mode;
  bit             m_err;

  int errors = 0;
  int checks = 0;
  int nb;

  always #5 clk = ~clk;

  hilo_acc_unit #(.W(W), .BYPASS(1'b1)) dut_byp (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_hi(wr_hi),
    .wr_lo(wr_lo), .rd_en(rd_en), .op_start(op_start), .op_mode(op_mode),
    .op_done(op_done), .op_res(op_res), .hi_out(hi_out1), .lo_out(lo_out1),
    .busy(busy1), .stall(stall1), .err(err1)
  );

  hilo_acc_unit #(.W(W), .BYPASS(1'b0)) dut_reg (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_hi(wr_hi),
    .wr_lo(wr_lo), .rd_en(rd_en), .op_start(op_start), .op_mode(op_mode),
    .op_done(op_done), .op_res(op_res), .hi_out(hi_out0), .lo_out(lo_out0),
    .busy(busy0), .stall(stall0), .err(err0)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    reset = 1'b0; wr_en = 1'b0; wr_sel = 2'b00; wr_hi = '0; wr_lo = '0;
    rd_en = 1'b0; op_start = 1'b0; op_mode = 2'b00; op_done = 1'b0; op_res = '0;
  endtask

  // Compare both DUTs against what the model says is visible this cycle
  task automatic check_outputs();
    logic [31:0] e_hi, e_lo;
    logic        e_stall;
    e_hi = m_acc[63:32];
    e_lo = m_acc[31:0];
    if (!m_busy && wr_en && wr_sel[1]) e_hi = wr_hi;
    if (!m_busy && wr_en && wr_sel[0]) e_lo = wr_lo;
    e_stall = m_busy && (rd_en || wr_en) && !op_done;
    check_eq("byp_hi", hi_out1, e_hi);
    check_eq("byp_lo", lo_out1, e_lo);
    check_eq("busy", busy1, m_busy);
    check_eq("stall", stall1, e_stall);
    check_eq("err", err1, m_err);
    check_eq("reg_hi", hi_out0, m_acc[63:32]);
    check_eq("reg_lo", lo_out0, m_acc[31:0]);
    check_eq("reg_busy_err_stall", {busy0, err0, stall0}, {m_busy, m_err, e_stall});
  endtask

  task automatic model_update();
    if (reset) begin
      m_acc = '0; m_busy = 0; m_mode = 2'b00; m_err = 0;
    end else if (!m_busy) begin
      if (wr_en && wr_sel[1]) m_acc[63:32] = wr_hi;
      if (wr_en && wr_sel[0]) m_acc[31:0]  = wr_lo;
      if (op_done) m_err = 1;
      if (op_start) begin
        m_busy = 1;
        m_mode = op_mode;
      end
    end else if (op_done) begin
      if (m_mode == 2'b01)      m_acc = m_acc + op_res;
      else if (m_mode == 2'b10) m_acc = m_acc - op_res;
      else                      m_acc = op_res;
      m_busy = op_start;
      if (op_start) m_mode = op_mode;
    end else if (op_start) begin
      m_err = 1;
    end
  endtask

  task automatic cyc();
    #1;
    check_outputs();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    @(posedge clk);
    m_acc = '0; m_busy = 0; m_mode = 2'b00; m_err = 0;
    @(negedge clk);
    cyc();
    idle_inputs();
    #1;
    check_eq("rst_outs", {hi_out1, lo_out1}, 64'h0);
    check_eq("rst_flags", {busy1, stall1, err1}, 3'b000);

    // Direct writes, both halves then LO only
    wr_en = 1; wr_sel = 2'b11; wr_hi = 32'h12345678; wr_lo = 32'h9ABCDEF0;
    #1;
    check_eq("wr_bypass_same_cycle", {hi_out1, lo_out1}, 64'h12345678_9ABCDEF0);
    check_eq("wr_nobypass_same_cycle", {hi_out0, lo_out0}, 64'h0);
    cyc();
    wr_sel = 2'b01; wr_hi = 32'hDEADBEEF; wr_lo = 32'h1;
    cyc();
    idle_inputs();
    #1;
    check_eq("wr_lo_only", {hi_out0, lo_out0}, 64'h12345678_00000001);

    // Accumulate with carry across LO->HI
    wr_en = 1; wr_sel = 2'b11; wr_hi = 32'h0; wr_lo = 32'hFFFFFFFF;
    cyc();
    idle_inputs(); op_start = 1; op_mode = 2'b01;
    cyc();
    idle_inputs();
    nb = 0;
    for (int i = 0; i < 2; i++) begin
      nb += busy1;
      cyc();
    end
    nb += busy1;
    op_done = 1; op_res = 64'h1;
    cyc();
    idle_inputs();
    #1;
    check_eq("busy_cycles", nb, 3);
    check_eq("add_carry", {hi_out1, lo_out1}, 64'h00000001_00000000);
    check_eq("add_idle", busy1, 1'b0);

    // Subtract wrap from zero
    reset = 1; cyc();
    idle_inputs(); op_start = 1; op_mode = 2'b10;
    cyc();
    idle_inputs(); op_done = 1; op_res = 64'h1;
    cyc();
    idle_inputs();
    #1;
    check_eq("sub_wrap", {hi_out1, lo_out1}, 64'hFFFFFFFF_FFFFFFFF);
    check_eq("sub_err", err1, 1'b0);

    // Stall and write drop while busy, write dropped at op_done
    wr_en = 1; wr_sel = 2'b11; wr_hi = 32'hAAAA0000; wr_lo = 32'h5555;
    cyc();
    idle_inputs(); op_start = 1; op_mode = 2'b00;
    cyc();
    idle_inputs(); rd_en = 1; wr_en = 1; wr_sel = 2'b11; wr_hi = 32'h1111; wr_lo = 32'h2222;
    #1;
    check_eq("stall_busy", stall1, 1'b1);
    cyc();
    check_eq("drop_while_busy", {hi_out1, lo_out1}, 64'hAAAA0000_00005555);
    op_done = 1; op_res = 64'h01234567_89ABCDEF;
    #1;
    check_eq("stall_done", stall1, 1'b0);
    cyc();
    idle_inputs();
    #1;
    check_eq("done_overwrite", {hi_out1, lo_out1}, 64'h01234567_89ABCDEF);

    // Back-to-back op_done + op_start
    op_start = 1; op_mode = 2'b01;
    cyc();
    idle_inputs(); op_done = 1; op_res = 64'h10; op_start = 1; op_mode = 2'b00;
    cyc();
    idle_inputs();
    #1;
    check_eq("b2b_busy", busy1, 1'b1);
    check_eq("b2b_first", {hi_out1, lo_out1}, 64'h01234567_89ABCDFF);
    op_done = 1; op_res = 64'hCAFEF00D_0BADC0DE;
    cyc();
    idle_inputs();
    #1;
    check_eq("b2b_second", {hi_out1, lo_out1}, 64'hCAFEF00D_0BADC0DE);
    check_eq("b2b_err", {busy1, err1}, 2'b00);

    // Stray op_done in idle, then reset mid-busy
    op_done = 1; op_res = 64'h77;
    cyc();
    idle_inputs();
    #1;
    check_eq("stray_err", err1, 1'b1);
    check_eq("stray_hold", {hi_out1, lo_out1}, 64'hCAFEF00D_0BADC0DE);
    op_start = 1; op_mode = 2'b01;
    cyc();
    idle_inputs(); reset = 1; op_done = 1; wr_en = 1; wr_sel = 2'b11; wr_hi = 32'h9; wr_lo = 32'h9;
    cyc();
    idle_inputs();
    #1;
    check_eq("rst_abort", {busy1, err1, hi_out1, lo_out1}, 66'h0);
    op_done = 1; op_res = 64'h5;
    cyc();
    idle_inputs();
    #1;
    check_eq("post_rst_stray", {err1, hi_out1, lo_out1}, {1'b1, 64'h0});

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      idle_inputs();
      reset    = ($urandom_range(0, 199) == 0);
      wr_en    = ($urandom_range(0, 2) == 0);
      wr_sel   = 2'($urandom_range(0, 3));
      wr_hi    = $urandom;
      wr_lo    = $urandom;
      rd_en    = ($urandom_range(0, 2) == 0);
      op_mode  = 2'($urandom_range(0, 3));
      op_res   = {$urandom, $urandom};
      if (m_busy) begin
        op_done  = ($urandom_range(0, 2) == 0);
        op_start = op_done ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      end else begin
        op_done  = ($urandom_range(0, 39) == 0);
        op_start = ($urandom_range(0, 3) == 0);
      end
      cyc();
    end

    idle_inputs();
    #1;
    check_outputs();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
